mandelbrot_iter_pipe: RTL and testbench

//  Pipelined escape-time engine for Mandelbrot/Julia pixels with up to 3 pixels in flight.

---
 rtl/mandelbrot_iter_pipe.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mandelbrot_iter_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_iter_pipe.sv
// mandelbrot_iter_pipe
//   Recirculating escape-time engine. Up to three pixel tokens occupy the
//   S0 -> S1 -> S2 loop at once, one token per stage. S2 either sends a token
//   back to S0 for another iteration or retires it into a single output
//   register. Each token carries its own x/y tag, so results can retire out of
//   order. Arithmetic is signed fixed point with FRAC fractional bits.
module mandelbrot_iter_pipe #(
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int ITER_W      = 10,
    parameter int X_W         = 10,
    parameter int Y_W         = 9
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [X_W-1:0]         in_x,
    input  logic [Y_W-1:0]         in_y,
    input  logic [WORD_LENGTH-1:0] re_p,
    input  logic [WORD_LENGTH-1:0] im_p,
    input  logic [WORD_LENGTH-1:0] re_k,
    input  logic [WORD_LENGTH-1:0] im_k,
    input  logic                   julia,
    input  logic [ITER_W-1:0]      max_iter,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [X_W-1:0]         out_x,
    output logic [Y_W-1:0]         out_y,
    output logic [ITER_W-1:0]      out_depth,
    output logic                   busy
);

    localparam int WL   = WORD_LENGTH;
    localparam int LO_W = WL / 2;        // unsigned low half of each operand
    localparam int HI_W = WL - LO_W;     // signed high half of each operand
    localparam int PW   = 2 * WL;        // exact square / cross-product width
    localparam int UW   = 2 * WL + 2;    // headroom for the z update sums

    // Escape threshold: |z|^2 > 4.0, with |z|^2 carrying 2*FRAC fraction bits.
    localparam logic signed [2*WL:0] ESC_LIM =
        $signed({{(2*WL-2){1'b0}}, 3'b100}) <<< (2*FRAC);

    // Everything a pixel needs while it circulates; c and z0 are frozen at accept.
    typedef struct packed {
        logic [X_W-1:0]       x;
        logic [Y_W-1:0]       y;
        logic signed [WL-1:0] re_z;
        logic signed [WL-1:0] im_z;
        logic signed [WL-1:0] re_c;
        logic signed [WL-1:0] im_c;
        logic [ITER_W-1:0]    max_iter;
        logic [ITER_W-1:0]    n;
        logic                 ovf;
    } token_t;

    // True when a wide signed value survives truncation to WL bits unchanged.
    function automatic logic fits_wl(input logic signed [UW-1:0] v);
        logic signed [WL-1:0] t;
        t = v[WL-1:0];
        return (UW'(t) == v);
    endfunction

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic   s0_v_r, s1_v_r, s2_v_r;
    token_t s0_tok_r, s1_tok_r, s2_tok_r;

    // S0 -> S1: half-word partial products
    logic signed [PW-1:0] pp_rr_hh_r, pp_rr_hl_r, pp_rr_ll_r;
    logic signed [PW-1:0] pp_ii_hh_r, pp_ii_hl_r, pp_ii_ll_r;
    logic signed [PW-1:0] pp_ri_hh_r, pp_ri_hl_r, pp_ri_lh_r, pp_ri_ll_r;

    // S1 -> S2: full squares and the escape flag
    logic signed [PW-1:0] sq_re_r, sq_im_r, sq_ri_r;
    logic                 esc_r;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic signed [HI_W-1:0] re_hi_s, im_hi_s;
    logic signed [LO_W:0]   re_lo_s, im_lo_s;
    logic signed [PW-1:0]   pp_rr_hh_s, pp_rr_hl_s, pp_rr_ll_s;
    logic signed [PW-1:0]   pp_ii_hh_s, pp_ii_hl_s, pp_ii_ll_s;
    logic signed [PW-1:0]   pp_ri_hh_s, pp_ri_hl_s, pp_ri_lh_s, pp_ri_ll_s;

    logic signed [PW-1:0]   sq_re_s, sq_im_s, sq_ri_s;
    logic signed [2*WL:0]   mag_s;
    logic                   esc_s;

    logic signed [UW-1:0]   re_full_s, im_full_s;
    logic                   retire_want_s;
    logic                   update_s;
    logic                   out_load_s;
    logic                   recirc_s;
    logic [ITER_W-1:0]      depth_s;
    token_t                 recirc_tok_s;

    logic                   accept_s;
    logic                   s0_v_nxt_s;
    token_t                 new_tok_s;
    token_t                 s0_tok_nxt_s;

    // S0: split z into signed-high / unsigned-low halves and form partial products
    always_comb begin
        re_hi_s = $signed(s0_tok_r.re_z[WL-1:LO_W]);
        im_hi_s = $signed(s0_tok_r.im_z[WL-1:LO_W]);
        re_lo_s = $signed({1'b0, s0_tok_r.re_z[LO_W-1:0]});
        im_lo_s = $signed({1'b0, s0_tok_r.im_z[LO_W-1:0]});

        pp_rr_hh_s = PW'(re_hi_s) * PW'(re_hi_s);
        pp_rr_hl_s = PW'(re_hi_s) * PW'(re_lo_s);
        pp_rr_ll_s = PW'(re_lo_s) * PW'(re_lo_s);

        pp_ii_hh_s = PW'(im_hi_s) * PW'(im_hi_s);
        pp_ii_hl_s = PW'(im_hi_s) * PW'(im_lo_s);
        pp_ii_ll_s = PW'(im_lo_s) * PW'(im_lo_s);

        pp_ri_hh_s = PW'(re_hi_s) * PW'(im_hi_s);
        pp_ri_hl_s = PW'(re_hi_s) * PW'(im_lo_s);
        pp_ri_lh_s = PW'(re_lo_s) * PW'(im_hi_s);
        pp_ri_ll_s = PW'(re_lo_s) * PW'(im_lo_s);
    end

    // S1: recombine partial products into exact squares and test for escape
    always_comb begin
        // a^2 = hh*2^(2L) + 2*hl*2^L + ll
        sq_re_s = (pp_rr_hh_r <<< (2*LO_W)) + (pp_rr_hl_r <<< (LO_W+1)) + pp_rr_ll_r;
        sq_im_s = (pp_ii_hh_r <<< (2*LO_W)) + (pp_ii_hl_r <<< (LO_W+1)) + pp_ii_ll_r;
        // a*b = hh*2^(2L) + (hl+lh)*2^L + ll
        sq_ri_s = (pp_ri_hh_r <<< (2*LO_W)) + ((pp_ri_hl_r + pp_ri_lh_r) <<< LO_W) + pp_ri_ll_r;

        mag_s = (2*WL+1)'(sq_re_s) + (2*WL+1)'(sq_im_s);
        esc_s = (mag_s > ESC_LIM);
    end

    // S2: compute the next z, decide retire / update / park, steer the loop
    always_comb begin
        re_full_s = (UW'(sq_re_r) >>> FRAC) - (UW'(sq_im_r) >>> FRAC)
                  + UW'($signed(s2_tok_r.re_c));
        im_full_s = ((UW'(sq_ri_r) <<< 1) >>> FRAC) + UW'($signed(s2_tok_r.im_c));

        retire_want_s = 1'b0;
        depth_s       = s2_tok_r.n;
        if (s2_v_r) begin
            if (s2_tok_r.ovf || esc_r) begin
                retire_want_s = 1'b1;
                depth_s       = s2_tok_r.n;
            end else if (s2_tok_r.n == s2_tok_r.max_iter) begin
                retire_want_s = 1'b1;
                depth_s       = s2_tok_r.max_iter;
            end else begin
                retire_want_s = 1'b0;
                depth_s       = s2_tok_r.n;
            end
        end else begin
            retire_want_s = 1'b0;
        end

        // A retiring token that finds the output register occupied parks:
        // it goes round again untouched and retries on its next S2 visit.
        out_load_s = retire_want_s & (~out_valid | out_ready);
        update_s   = s2_v_r & ~retire_want_s;
        recirc_s   = s2_v_r & ~out_load_s;
        in_ready   = ~recirc_s;

        recirc_tok_s = s2_tok_r;
        if (update_s) begin
            recirc_tok_s.re_z = re_full_s[WL-1:0];
            recirc_tok_s.im_z = im_full_s[WL-1:0];
            recirc_tok_s.n    = s2_tok_r.n + ITER_W'(1'b1);
            recirc_tok_s.ovf  = s2_tok_r.ovf | ~fits_wl(re_full_s) | ~fits_wl(im_full_s);
        end else begin
            recirc_tok_s = s2_tok_r;
        end
    end

    // S0 input mux: recirculating token has priority over a new pixel
    always_comb begin
        accept_s = in_valid & in_ready;

        new_tok_s          = '0;
        new_tok_s.x        = in_x;
        new_tok_s.y        = in_y;
        new_tok_s.max_iter = max_iter;
        new_tok_s.n        = {ITER_W{1'b0}};
        new_tok_s.ovf      = 1'b0;
        if (julia) begin
            new_tok_s.re_z = $signed(re_p);
            new_tok_s.im_z = $signed(im_p);
            new_tok_s.re_c = $signed(re_k);
            new_tok_s.im_c = $signed(im_k);
        end else begin
            new_tok_s.re_z = {WL{1'b0}};
            new_tok_s.im_z = {WL{1'b0}};
            new_tok_s.re_c = $signed(re_p);
            new_tok_s.im_c = $signed(im_p);
        end

        s0_v_nxt_s   = 1'b0;
        s0_tok_nxt_s = s0_tok_r;
        if (recirc_s) begin
            s0_v_nxt_s   = 1'b1;
            s0_tok_nxt_s = recirc_tok_s;
        end else if (accept_s) begin
            s0_v_nxt_s   = 1'b1;
            s0_tok_nxt_s = new_tok_s;
        end else begin
            s0_v_nxt_s   = 1'b0;
            s0_tok_nxt_s = s0_tok_r;
        end
    end

    // Stage valid bits and busy flag; reset discards every in-flight token
    always_ff @(posedge sysclk) begin
        if (reset) begin
            s0_v_r <= 1'b0;
            s1_v_r <= 1'b0;
            s2_v_r <= 1'b0;
            busy   <= 1'b0;
        end else begin
            s0_v_r <= s0_v_nxt_s;
            s1_v_r <= s0_v_r;
            s2_v_r <= s1_v_r;
            busy   <= s0_v_nxt_s | s0_v_r | s1_v_r;
        end
    end

    // Stage payload registers; qualified by the valid bits, so no reset needed
    always_ff @(posedge sysclk) begin
        s0_tok_r   <= s0_tok_nxt_s;

        s1_tok_r   <= s0_tok_r;
        pp_rr_hh_r <= pp_rr_hh_s;
        pp_rr_hl_r <= pp_rr_hl_s;
        pp_rr_ll_r <= pp_rr_ll_s;
        pp_ii_hh_r <= pp_ii_hh_s;
        pp_ii_hl_r <= pp_ii_hl_s;
        pp_ii_ll_r <= pp_ii_ll_s;
        pp_ri_hh_r <= pp_ri_hh_s;
        pp_ri_hl_r <= pp_ri_hl_s;
        pp_ri_lh_r <= pp_ri_lh_s;
        pp_ri_ll_r <= pp_ri_ll_s;

        s2_tok_r   <= s1_tok_r;
        sq_re_r    <= sq_re_s;
        sq_im_r    <= sq_im_s;
        sq_ri_r    <= sq_ri_s;
        esc_r      <= esc_s;
    end

    // Output register: load on retire, hold while stalled, drop after handshake
    always_ff @(posedge sysclk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_x     <= {X_W{1'b0}};
            out_y     <= {Y_W{1'b0}};
            out_depth <= {ITER_W{1'b0}};
        end else if (out_load_s) begin
            out_valid <= 1'b1;
            out_x     <= s2_tok_r.x;
            out_y     <= s2_tok_r.y;
            out_depth <= depth_s;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_mandelbrot_iter_pipe.sv
// tb_mandelbrot_iter_pipe
//   Directed vectors with hand-computed escape depths and latencies, an
//   out-of-order pair, output back-pressure with draining, and mid-flight reset.
module tb_mandelbrot_iter_pipe;

    localparam int WL     = 32;
    localparam int ITER_W = 10;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;

    // Q4.28 constants
    localparam logic [WL-1:0] Q_0   = 32'h0000_0000;
    localparam logic [WL-1:0] Q_1   = 32'h1000_0000;
    localparam logic [WL-1:0] Q_2   = 32'h2000_0000;
    localparam logic [WL-1:0] Q_3   = 32'h3000_0000;
    localparam logic [WL-1:0] Q_7   = 32'h7000_0000;
    localparam logic [WL-1:0] Q_M1  = 32'hF000_0000;
    localparam logic [WL-1:0] Q_M2  = 32'hE000_0000;

    logic              sysclk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [X_W-1:0]    in_x = '0;
    logic [Y_W-1:0]    in_y = '0;
    logic [WL-1:0]     re_p = '0, im_p = '0, re_k = '0, im_k = '0;
    logic              julia = 1'b0;
    logic [ITER_W-1:0] max_iter = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [X_W-1:0]    out_x;
    logic [Y_W-1:0]    out_y;
    logic [ITER_W-1:0] out_depth;
    logic              busy;

    mandelbrot_iter_pipe dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .re_p      (re_p),
        .im_p      (im_p),
        .re_k      (re_k),
        .im_k      (im_k),
        .julia     (julia),
        .max_iter  (max_iter),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_depth (out_depth),
        .busy      (busy)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Result monitor: one entry per output handshake
    int mon_x[$];
    int mon_y[$];
    int mon_d[$];
    int mon_c[$];
    always @(negedge sysclk) begin
        if (!reset && out_valid && out_ready) begin
            mon_x.push_back(int'(out_x));
            mon_y.push_back(int'(out_y));
            mon_d.push_back(int'(out_depth));
            mon_c.push_back(cyc);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mon_x.delete();
        mon_y.delete();
        mon_d.delete();
        mon_c.delete();
    endtask

    // Present one pixel until accepted; acc = cycle stamp of the accept edge
    task automatic send(input int x, input int y, input logic [WL-1:0] rp, input logic [WL-1:0] ip,
                        input logic [WL-1:0] rk, input logic [WL-1:0] ik, input logic jul,
                        input int mi, output int acc);
        acc = -1;
        @(posedge sysclk); #1;
        in_valid = 1'b1;
        in_x = x[X_W-1:0];
        in_y = y[Y_W-1:0];
        re_p = rp; im_p = ip; re_k = rk; im_k = ik;
        julia = jul;
        max_iter = mi[ITER_W-1:0];
        for (int i = 0; i < 200; i++) begin
            @(negedge sysclk);
            if (in_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        @(posedge sysclk); #1;
        // Scramble the ports: in-flight pixels must not notice
        in_valid = 1'b0;
        re_p = $urandom(); im_p = $urandom(); re_k = $urandom(); im_k = $urandom();
        julia = 1'($urandom());
        max_iter = ITER_W'($urandom());
        chk("accepted", (acc >= 0), 1);
    endtask

    // Wait (bounded) for the result carrying tag x and remove it from the monitor
    task automatic get_result(input int x, input int budget, output int y, output int d,
                              output int c, output bit found);
        int idx;
        idx = -1; found = 1'b0; y = -1; d = -1; c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge sysclk); #1;
            foreach (mon_x[k]) if (idx < 0 && mon_x[k] == x) idx = k;
            if (idx >= 0) break;
        end
        if (idx >= 0) begin
            found = 1'b1;
            y = mon_y[idx]; d = mon_d[idx]; c = mon_c[idx];
            mon_x.delete(idx); mon_y.delete(idx); mon_d.delete(idx); mon_c.delete(idx);
        end
    endtask

    typedef struct {
        string         name;
        int            x, y;
        logic [WL-1:0] rp, ip, rk, ik;
        logic          jul;
        int            mi;
        int            depth;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_a, acc_b, y, d, c, cnt, k;
        bit f;
        int tags[$];

        vecs[0] = '{"m_c0",      1,  2, Q_0,  Q_0, Q_0, Q_0, 1'b0, 10, 10};
        vecs[1] = '{"m_c2",      3,  4, Q_2,  Q_0, Q_0, Q_0, 1'b0, 50, 2};
        vecs[2] = '{"m_cm2",     5,  6, Q_M2, Q_0, Q_0, Q_0, 1'b0, 20, 20};
        vecs[3] = '{"j_p3",      7,  8, Q_3,  Q_0, Q_0, Q_0, 1'b1, 10, 0};
        vecs[4] = '{"m_p3",      9, 10, Q_3,  Q_0, Q_0, Q_0, 1'b0, 10, 1};
        vecs[5] = '{"m_cm1i1",  11, 12, Q_M1, Q_1, Q_0, Q_0, 1'b0, 50, 3};
        vecs[6] = '{"m_ci1",    13, 14, Q_0,  Q_1, Q_0, Q_0, 1'b0, 20, 20};
        vecs[7] = '{"m_max0",   15, 16, Q_0,  Q_0, Q_0, Q_0, 1'b0, 0,  0};
        vecs[8] = '{"j_ovf",    17, 18, Q_2,  Q_0, Q_7, Q_0, 1'b1, 10, 1};

        // Reset state
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b0;
        @(negedge sysclk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_depth", out_depth, 0);
        chk("rst_in_ready", in_ready, 1);

        // Directed single pixels: depth, latency 3*(d+1), tag echo
        foreach (vecs[i]) begin
            send(vecs[i].x, vecs[i].y, vecs[i].rp, vecs[i].ip, vecs[i].rk, vecs[i].ik,
                 vecs[i].jul, vecs[i].mi, acc);
            get_result(vecs[i].x, 3 * (vecs[i].depth + 1) + 20, y, d, c, f);
            chk({vecs[i].name, "_found"}, f, 1);
            chk({vecs[i].name, "_y"}, y, vecs[i].y);
            chk({vecs[i].name, "_depth"}, d, vecs[i].depth);
            chk({vecs[i].name, "_lat"}, c - acc, 3 * (vecs[i].depth + 1));
            repeat (2) @(posedge sysclk);
        end

        // Out-of-order retire: long pixel A, then short pixel B overtakes it
        clear_mon();
        send(100, 20, Q_0, Q_0, Q_0, Q_0, 1'b0, 10, acc_a);
        send(101, 21, Q_3, Q_0, Q_0, Q_0, 1'b0, 10, acc_b);
        get_result(101, 30, y, d, c, f);
        chk("ooo_b_depth", d, 1);
        chk("ooo_b_lat", c - acc_b, 6);
        chk("ooo_a_not_yet", mon_x.size(), 0);
        get_result(100, 60, y, d, c, f);
        chk("ooo_a_depth", d, 10);
        chk("ooo_a_lat", c - acc_a, 33);

        // Back-pressure: out_ready low, continuous max_iter=0 stream
        repeat (3) @(posedge sysclk);
        clear_mon();
        #1;
        out_ready = 1'b0;
        k = 200;
        in_valid = 1'b1; julia = 1'b0; max_iter = '0;
        re_p = Q_0; im_p = Q_0; re_k = Q_0; im_k = Q_0;
        in_x = k[X_W-1:0]; in_y = 9'd7;
        for (int i = 0; i < 30; i++) begin
            @(negedge sysclk);
            if (in_ready) begin
                tags.push_back(k);
                k++;
            end
            @(posedge sysclk); #1;
            in_x = k[X_W-1:0];
        end
        in_valid = 1'b0;
        @(negedge sysclk);
        chk("bp_accepts", tags.size(), 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_busy", busy, 1);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_x_held", out_x, 200);
        chk("bp_no_handshake", mon_x.size(), 0);
        @(posedge sysclk); #1;
        out_ready = 1'b1;
        repeat (25) @(posedge sysclk);
        @(negedge sysclk);
        chk("bp_drain_count", mon_x.size(), 4);
        for (int t = 200; t < 204; t++) begin
            cnt = 0;
            foreach (mon_x[j]) if (mon_x[j] == t) begin
                cnt++;
                chk("bp_drain_depth", mon_d[j], 0);
            end
            chk("bp_tag_once", cnt, 1);
        end
        chk("bp_idle_busy", busy, 0);

        // Mid-flight reset with three long pixels in the loop
        clear_mon();
        send(300, 1, Q_0, Q_0, Q_0, Q_0, 1'b0, 500, acc);
        send(301, 1, Q_0, Q_0, Q_0, Q_0, 1'b0, 500, acc);
        send(302, 1, Q_0, Q_0, Q_0, Q_0, 1'b0, 500, acc);
        @(negedge sysclk);
        chk("mid_busy_before", busy, 1);
        @(posedge sysclk); #1;
        reset = 1'b1;
        @(posedge sysclk); #1;
        reset = 1'b0;
        @(negedge sysclk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        send(310, 5, Q_2, Q_0, Q_0, Q_0, 1'b0, 50, acc);
        get_result(310, 40, y, d, c, f);
        chk("post_rst_found", f, 1);
        chk("post_rst_depth", d, 2);
        chk("post_rst_lat", c - acc, 9);
        repeat (20) @(posedge sysclk);
        @(negedge sysclk);
        chk("post_rst_no_stale", mon_x.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
